// File: rtl/blackparrot_fpga_host_io_master.sv
// Host-to-BlackParrot MMIO initiator.
// The host streams 32b command words (hdr, addr_lo, addr_hi[, data_lo, data_hi])
// into a command FIFO. An FSM turns each command into one single-beat AXI4 read
// or write, and read data returns to the host through a response FIFO.
// Optional feature macro: BP_HOST_IO_MASTER_WRITE_ACK_EN. When it is defined,
// every write also returns one response word {30'b0, bresp}.
module blackparrot_fpga_host_io_master #(
   parameter int M_AXI_ADDR_WIDTH  = 64,
   parameter int M_AXI_DATA_WIDTH  = 64,
   parameter int M_AXI_ID_WIDTH    = 4,
   parameter int fifo_data_width_p = 32,
   parameter int HOST_FIFO_ELS     = 64
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          cmd_v_i,
   input  logic [fifo_data_width_p-1:0]  cmd_data_i,
   output logic                          cmd_ready_and_o,
   output logic                          resp_v_o,
   output logic [fifo_data_width_p-1:0]  resp_data_o,
   input  logic                          resp_yumi_i,
   output logic [31:0]                   resp_count_o,
   output logic [31:0]                   error_count_o,
   output logic [M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic                          m_axi_awvalid,
   output logic [2:0]                    m_axi_awsize,
   input  logic                          m_axi_awready,
   output logic [M_AXI_ID_WIDTH-1:0]     m_axi_awid,
   output logic [7:0]                    m_axi_awlen,
   output logic [1:0]                    m_axi_awburst,
   output logic                          m_axi_awlock,
   output logic [3:0]                    m_axi_awcache,
   output logic [2:0]                    m_axi_awprot,
   output logic [3:0]                    m_axi_awqos,
   output logic [3:0]                    m_axi_awregion,
   output logic [M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                          m_axi_wvalid,
   output logic                          m_axi_wlast,
   input  logic                          m_axi_wready,
   input  logic                          m_axi_bvalid,
   input  logic [M_AXI_ID_WIDTH-1:0]     m_axi_bid,
   input  logic [1:0]                    m_axi_bresp,
   output logic                          m_axi_bready,
   output logic [M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic                          m_axi_arvalid,
   output logic [2:0]                    m_axi_arsize,
   input  logic                          m_axi_arready,
   output logic [M_AXI_ID_WIDTH-1:0]     m_axi_arid,
   output logic [7:0]                    m_axi_arlen,
   output logic [1:0]                    m_axi_arburst,
   output logic                          m_axi_arlock,
   output logic [3:0]                    m_axi_arcache,
   output logic [2:0]                    m_axi_arprot,
   output logic [3:0]                    m_axi_arqos,
   output logic [3:0]                    m_axi_arregion,
   input  logic [M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic                          m_axi_rvalid,
   input  logic [M_AXI_ID_WIDTH-1:0]     m_axi_rid,
   input  logic                          m_axi_rlast,
   input  logic [1:0]                    m_axi_rresp,
   output logic                          m_axi_rready
);

   localparam int ptr_w = $clog2(HOST_FIFO_ELS);
   localparam logic [ptr_w:0] fifo_full_cnt = (ptr_w+1)'(HOST_FIFO_ELS);

   localparam logic [3:0] S_HDR  = 4'd0;
   localparam logic [3:0] S_ALO  = 4'd1;
   localparam logic [3:0] S_AHI  = 4'd2;
   localparam logic [3:0] S_DLO  = 4'd3;
   localparam logic [3:0] S_DHI  = 4'd4;
   localparam logic [3:0] S_AW_W = 4'd5;
   localparam logic [3:0] S_B    = 4'd6;
   localparam logic [3:0] S_AR   = 4'd7;
   localparam logic [3:0] S_R    = 4'd8;
   localparam logic [3:0] S_RLO  = 4'd9;
   localparam logic [3:0] S_RHI  = 4'd10;
`ifdef BP_HOST_IO_MASTER_WRITE_ACK_EN
   localparam logic [3:0] S_ACK  = 4'd11;
   logic [1:0] bresp_r;
`endif

   logic [3:0]  state_r;
   logic        is_write_r;
   logic [1:0]  size_r;
   logic [63:0] addr_r, data_r, rdata_r;
   logic [63:0] rdata_shifted, rdata_aligned;
   logic [7:0]  byte_mask;
   logic        awvalid_r, wvalid_r, arvalid_r;
   logic [31:0] error_count_r;
   logic        err_hit;

   // Command FIFO: power-of-two depth, so the pointers wrap on their own
   logic [31:0]    cmd_mem [HOST_FIFO_ELS];
   logic [ptr_w-1:0] cmd_wptr, cmd_rptr;
   logic [ptr_w:0] cmd_count;
   logic           cmd_v, cmd_push, cmd_pop, fetch;
   logic [31:0]    cmd_word;

   // Response FIFO: filled only by the FSM, drained by the host
   logic [31:0]    resp_mem [HOST_FIFO_ELS];
   logic [ptr_w-1:0] resp_wptr, resp_rptr;
   logic [ptr_w:0] resp_count;
   logic           resp_ready, resp_push_v, resp_push, resp_pop;
   logic [31:0]    resp_push_data;

   logic unused_axi_bits;
   assign unused_axi_bits = ^{m_axi_bid, m_axi_rid, m_axi_rlast};

   assign fetch = (state_r == S_HDR) || (state_r == S_ALO) || (state_r == S_AHI)
               || (state_r == S_DLO) || (state_r == S_DHI);
   assign cmd_v           = (cmd_count != '0);
   assign cmd_word        = cmd_mem[cmd_rptr];
   assign cmd_ready_and_o = (cmd_count != fifo_full_cnt);
   assign cmd_push        = cmd_v_i & cmd_ready_and_o;
   assign cmd_pop         = cmd_v & fetch;

   assign resp_ready   = (resp_count != fifo_full_cnt);
   assign resp_v_o     = (resp_count != '0);
   assign resp_data_o  = resp_mem[resp_rptr];
   assign resp_push    = resp_push_v & resp_ready;
   assign resp_pop     = resp_yumi_i & resp_v_o;
   assign resp_count_o = 32'(resp_count);

   // Command storage; occupancy gates every read so no reset is needed
   always_ff @(posedge clk_i) begin
      if (cmd_push) cmd_mem[cmd_wptr] <= cmd_data_i;
   end

   // Command FIFO pointers and occupancy
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cmd_wptr  <= '0;
         cmd_rptr  <= '0;
         cmd_count <= '0;
      end else begin
         if (cmd_push) cmd_wptr <= cmd_wptr + ptr_w'(1);
         if (cmd_pop)  cmd_rptr <= cmd_rptr + ptr_w'(1);
         cmd_count <= cmd_count + (ptr_w+1)'(cmd_push) - (ptr_w+1)'(cmd_pop);
      end
   end

   // Response storage
   always_ff @(posedge clk_i) begin
      if (resp_push) resp_mem[resp_wptr] <= resp_push_data;
   end

   // Response FIFO pointers and occupancy
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         resp_wptr  <= '0;
         resp_rptr  <= '0;
         resp_count <= '0;
      end else begin
         if (resp_push) resp_wptr <= resp_wptr + ptr_w'(1);
         if (resp_pop)  resp_rptr <= resp_rptr + ptr_w'(1);
         resp_count <= resp_count + (ptr_w+1)'(resp_push) - (ptr_w+1)'(resp_pop);
      end
   end

   // Byte lane enables for the access size, and read data realigned to byte 0
   always_comb begin
      rdata_shifted = m_axi_rdata >> {addr_r[2:0], 3'b000};
      case (size_r)
         2'd0: begin byte_mask = 8'h01; rdata_aligned = {56'b0, rdata_shifted[7:0]};  end
         2'd1: begin byte_mask = 8'h03; rdata_aligned = {48'b0, rdata_shifted[15:0]}; end
         2'd2: begin byte_mask = 8'h0F; rdata_aligned = {32'b0, rdata_shifted[31:0]}; end
         default: begin byte_mask = 8'hFF; rdata_aligned = rdata_shifted; end
      endcase
   end

   // Words the FSM offers to the response FIFO in its push states
   always_comb begin
      resp_push_v    = 1'b0;
      resp_push_data = '0;
      case (state_r)
         S_RLO: begin resp_push_v = 1'b1; resp_push_data = rdata_r[31:0];  end
         S_RHI: begin resp_push_v = 1'b1; resp_push_data = rdata_r[63:32]; end
`ifdef BP_HOST_IO_MASTER_WRITE_ACK_EN
         S_ACK: begin resp_push_v = 1'b1; resp_push_data = {30'b0, bresp_r}; end
`endif
         default: ;
      endcase
   end

   assign m_axi_awaddr   = addr_r;
   assign m_axi_awsize   = {1'b0, size_r};
   assign m_axi_awvalid  = awvalid_r;
   assign m_axi_awid     = '0;
   assign m_axi_awlen    = 8'd0;
   assign m_axi_awburst  = 2'b01;
   assign m_axi_awlock   = 1'b0;
   assign m_axi_awcache  = 4'b0011;
   assign m_axi_awprot   = 3'b000;
   assign m_axi_awqos    = 4'b0000;
   assign m_axi_awregion = 4'b0000;
   assign m_axi_wdata    = data_r << {addr_r[2:0], 3'b000};
   assign m_axi_wstrb    = byte_mask << addr_r[2:0];
   assign m_axi_wvalid   = wvalid_r;
   assign m_axi_wlast    = 1'b1;
   assign m_axi_bready   = (state_r == S_B);
   assign m_axi_araddr   = addr_r;
   assign m_axi_arsize   = {1'b0, size_r};
   assign m_axi_arvalid  = arvalid_r;
   assign m_axi_arid     = '0;
   assign m_axi_arlen    = 8'd0;
   assign m_axi_arburst  = 2'b01;
   assign m_axi_arlock   = 1'b0;
   assign m_axi_arcache  = 4'b0011;
   assign m_axi_arprot   = 3'b000;
   assign m_axi_arqos    = 4'b0000;
   assign m_axi_arregion = 4'b0000;
   assign m_axi_rready   = (state_r == S_R);

   assign err_hit = ((state_r == S_B) && m_axi_bvalid && (m_axi_bresp != 2'b00))
                 || ((state_r == S_R) && m_axi_rvalid && (m_axi_rresp != 2'b00));
   assign error_count_o = error_count_r;

   // Saturating count of error responses from the slave
   always_ff @(posedge clk_i) begin
      if (reset_i)                               error_count_r <= '0;
      else if (err_hit && (error_count_r != '1)) error_count_r <= error_count_r + 32'd1;
   end

   // Command sequencer: fetch words, run one AXI transaction, return its results
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r    <= S_HDR;
         is_write_r <= 1'b0;
         size_r     <= '0;
         addr_r     <= '0;
         data_r     <= '0;
         rdata_r    <= '0;
         awvalid_r  <= 1'b0;
         wvalid_r   <= 1'b0;
         arvalid_r  <= 1'b0;
`ifdef BP_HOST_IO_MASTER_WRITE_ACK_EN
         bresp_r    <= '0;
`endif
      end else begin
         case (state_r)
            S_HDR: if (cmd_v) begin
               is_write_r <= cmd_word[0];
               size_r     <= cmd_word[2:1];
               state_r    <= S_ALO;
            end
            S_ALO: if (cmd_v) begin
               addr_r[31:0] <= cmd_word;
               state_r      <= S_AHI;
            end
            S_AHI: if (cmd_v) begin
               addr_r[63:32] <= cmd_word;
               if (is_write_r) begin
                  state_r <= S_DLO;
               end else begin
                  arvalid_r <= 1'b1;
                  state_r   <= S_AR;
               end
            end
            S_DLO: if (cmd_v) begin
               data_r[31:0] <= cmd_word;
               state_r      <= S_DHI;
            end
            S_DHI: if (cmd_v) begin
               data_r[63:32] <= cmd_word;
               awvalid_r     <= 1'b1;
               wvalid_r      <= 1'b1;
               state_r       <= S_AW_W;
            end
            S_AW_W: begin
               if (m_axi_awready) awvalid_r <= 1'b0;
               if (m_axi_wready)  wvalid_r  <= 1'b0;
               if ((!awvalid_r || m_axi_awready) && (!wvalid_r || m_axi_wready))
                  state_r <= S_B;
            end
            S_B: if (m_axi_bvalid) begin
`ifdef BP_HOST_IO_MASTER_WRITE_ACK_EN
               bresp_r <= m_axi_bresp;
               state_r <= S_ACK;
            end
            S_ACK: if (resp_ready) begin
`endif
               state_r <= S_HDR;
            end
            S_AR: if (m_axi_arready) begin
               arvalid_r <= 1'b0;
               state_r   <= S_R;
            end
            S_R: if (m_axi_rvalid) begin
               rdata_r <= rdata_aligned;
               state_r <= S_RLO;
            end
            S_RLO: if (resp_ready) state_r <= S_RHI;
            S_RHI: if (resp_ready) state_r <= S_HDR;
            default: state_r <= S_HDR;
         endcase
      end
   end

endmodule

// File: tb/tb_blackparrot_fpga_host_io_master.sv
// Scoreboard bench for blackparrot_fpga_host_io_master: host command driver,
// AXI slave model with random readiness, and a host response monitor. Build
// with +define+BP_HOST_IO_MASTER_WRITE_ACK_EN to expect write ack words.
module tb_blackparrot_fpga_host_io_master;
   localparam int IDW = 4;

   logic clk_i = 1'b0;
   logic reset_i;
   always #5 clk_i = ~clk_i;

   logic        cmd_v_i, cmd_ready_and_o, resp_v_o, resp_yumi_i;
   logic [31:0] cmd_data_i, resp_data_o, resp_count_o, error_count_o;
   logic [63:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
   logic        m_axi_awvalid, m_axi_awready, m_axi_awlock, m_axi_arvalid, m_axi_arready, m_axi_arlock;
   logic [2:0]  m_axi_awsize, m_axi_awprot, m_axi_arsize, m_axi_arprot;
   logic [IDW-1:0] m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
   logic [7:0]  m_axi_awlen, m_axi_arlen, m_axi_wstrb;
   logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
   logic [3:0]  m_axi_awcache, m_axi_awqos, m_axi_awregion, m_axi_arcache, m_axi_arqos, m_axi_arregion;
   logic        m_axi_wvalid, m_axi_wlast, m_axi_wready, m_axi_bvalid, m_axi_bready;
   logic        m_axi_rvalid, m_axi_rlast, m_axi_rready;

   blackparrot_fpga_host_io_master dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .cmd_v_i(cmd_v_i), .cmd_data_i(cmd_data_i), .cmd_ready_and_o(cmd_ready_and_o),
      .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi_i),
      .resp_count_o(resp_count_o), .error_count_o(error_count_o),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awsize(m_axi_awsize),
      .m_axi_awready(m_axi_awready), .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen),
      .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
      .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos), .m_axi_awregion(m_axi_awregion),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
      .m_axi_wlast(m_axi_wlast), .m_axi_wready(m_axi_wready),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
      .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arsize(m_axi_arsize),
      .m_axi_arready(m_axi_arready), .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen),
      .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache),
      .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos), .m_axi_arregion(m_axi_arregion),
      .m_axi_rdata(m_axi_rdata), .m_axi_rvalid(m_axi_rvalid), .m_axi_rid(m_axi_rid),
      .m_axi_rlast(m_axi_rlast), .m_axi_rresp(m_axi_rresp), .m_axi_rready(m_axi_rready)
   );

   typedef struct { logic [63:0] addr; logic [2:0] size; logic [63:0] wdata; logic [7:0] wstrb; } wr_t;
   typedef struct { logic [63:0] addr; logic [2:0] size; logic [63:0] rdata; logic [1:0] rresp; } rd_t;

   wr_t         expW[$];
   rd_t         expR[$];
   logic [1:0]  bRespQ[$];
   logic [31:0] expResp[$];

   int checks = 0, fails = 0, errExp = 0, cyc = 0;
   int readyMode = 0, awDelay = 0, yumiEn = 1;
   int awHs = 0, wHs = 0, bHs = 0, awHsCyc = 0, wHsCyc = 0, awVCnt = 0, lastAwVCnt = 0;
   int hdrCyc = 0, awRiseCyc = 0;
   bit awSeen = 0, wSeen = 0, bPending = 0, bTaken = 0, rPending = 0, rTaken = 0, awvPrev = 0;
   logic [1:0]  curB = 0, curRResp = 0;
   logic [63:0] curRData = 0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic failNote(input string name);
      checks++;
      fails++;
      $display("[TB] FAIL %s: got event, expected none (or bound expired)", name);
   endtask

   // Offer one command word and hold it until the FIFO accepts it
   task automatic pushWord(input logic [31:0] w);
      int n = 0;
      @(negedge clk_i);
      cmd_v_i = 1'b1;
      cmd_data_i = w;
      while (!cmd_ready_and_o && n < 3000) begin @(negedge clk_i); n++; end
      if (n >= 3000) failNote("cmd_push_timeout");
      @(posedge clk_i);
      #1 cmd_v_i = 1'b0;
   endtask

   // Issue one command, recording what the slave and host should observe
   task automatic applyStimulus(input bit w, input logic [1:0] size, input logic [63:0] addr,
                                input logic [63:0] data, input logic [1:0] resp);
      int nb, off;
      wr_t e;
      logic [63:0] ret;
      nb  = 1 << size;
      off = int'(addr[2:0]);
      if (w) begin
         e.addr = addr; e.size = {1'b0, size}; e.wdata = data << (8 * off); e.wstrb = '0;
         for (int i = 0; i < nb; i++) e.wstrb[off + i] = 1'b1;
         expW.push_back(e);
         bRespQ.push_back(resp);
`ifdef BP_HOST_IO_MASTER_WRITE_ACK_EN
         expResp.push_back({30'b0, resp});
`endif
      end else begin
         ret = '0;
         for (int i = 0; i < nb; i++) ret[i*8 +: 8] = data[(off + i)*8 +: 8];
         expR.push_back('{addr, {1'b0, size}, data, resp});
         expResp.push_back(ret[31:0]);
         expResp.push_back(ret[63:32]);
      end
      if (resp != 2'b00) errExp++;
      pushWord({29'($urandom), size, w});
      hdrCyc = cyc;
      pushWord(addr[31:0]);
      pushWord(addr[63:32]);
      if (w) begin
         pushWord(data[31:0]);
         pushWord(data[63:32]);
      end
   endtask

   task automatic randCmd(input int kind);
      logic [1:0]  sz;
      logic [63:0] addr, data;
      logic [1:0]  resp;
      int nb, off;
      bit w;
      sz   = 2'($urandom_range(0, 3));
      nb   = 1 << sz;
      off  = ($urandom_range(0, 7) / nb) * nb;
      addr = {$urandom, $urandom};
      addr[2:0] = 3'(off);
      data = {$urandom, $urandom};
      resp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      w    = (kind == 2) ? 1'($urandom_range(0, 1)) : (kind == 1);
      applyStimulus(w, sz, addr, data, resp);
   endtask

   task automatic waitIdle();
      int n = 0;
      while (!(expW.size() == 0 && expR.size() == 0 && expResp.size() == 0 && !bPending
               && !rPending && !m_axi_bvalid && !m_axi_rvalid) && n < 8000) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 8000) failNote("idle_timeout");
      repeat (4) @(negedge clk_i);
   endtask

   // AXI slave: random readiness, B after both AW and W, R after AR
   initial begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
      m_axi_bid = '0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rid = '0; m_axi_rlast = 0;
      forever begin
         @(negedge clk_i);
         if (reset_i) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0; m_axi_bvalid = 0; m_axi_rvalid = 0;
            bPending = 0; bTaken = 0; rPending = 0; rTaken = 0; awSeen = 0; wSeen = 0;
         end else begin
            if (m_axi_bvalid && bTaken) begin m_axi_bvalid = 0; bTaken = 0; end
            if (!m_axi_bvalid && bPending && $urandom_range(0, 1) == 1) begin
               m_axi_bvalid = 1; m_axi_bresp = curB;
            end
            if (m_axi_rvalid && rTaken) begin m_axi_rvalid = 0; rTaken = 0; end
            if (!m_axi_rvalid && rPending && $urandom_range(0, 1) == 1) begin
               m_axi_rvalid = 1; m_axi_rdata = curRData; m_axi_rresp = curRResp; m_axi_rlast = 1;
            end
            if (readyMode == 1) begin
               m_axi_awready = 1; m_axi_wready = 1; m_axi_arready = 1;
            end else begin
               m_axi_awready = 1'($urandom_range(0, 1));
               m_axi_wready  = 1'($urandom_range(0, 1));
               m_axi_arready = 1'($urandom_range(0, 1));
            end
            if (awDelay > 0 && m_axi_awvalid) begin m_axi_awready = 0; awDelay--; end
            #1;
            if (m_axi_awvalid && !awvPrev) awRiseCyc = cyc;
            awvPrev = m_axi_awvalid;
            if (m_axi_awvalid) awVCnt++;
            if (m_axi_awvalid && m_axi_awready) begin
               awHs++; awHsCyc = cyc; lastAwVCnt = awVCnt; awVCnt = 0; awSeen = 1;
               if (expW.size() == 0) failNote("aw_unexpected");
               else begin
                  checkOutput("awaddr", m_axi_awaddr, expW[0].addr);
                  checkOutput("awsize", 64'(m_axi_awsize), 64'(expW[0].size));
                  checkOutput("aw_len_burst_cache", {m_axi_awlen, m_axi_awburst, m_axi_awcache}, 64'h0013);
               end
            end
            if (m_axi_wvalid && m_axi_wready) begin
               wHs++; wHsCyc = cyc; wSeen = 1;
               if (expW.size() == 0) failNote("w_unexpected");
               else begin
                  checkOutput("wdata", m_axi_wdata, expW[0].wdata);
                  checkOutput("wstrb", 64'(m_axi_wstrb), 64'(expW[0].wstrb));
                  checkOutput("wlast", 64'(m_axi_wlast), 64'd1);
               end
            end
            if (awSeen && wSeen) begin
               awSeen = 0; wSeen = 0; bPending = 1;
               if (expW.size() != 0) expW.delete(0);
               curB = (bRespQ.size() != 0) ? bRespQ.pop_front() : 2'b00;
            end
            if (m_axi_bvalid && m_axi_bready) begin bHs++; bTaken = 1; bPending = 0; end
            if (m_axi_arvalid && m_axi_arready) begin
               if (expR.size() == 0) failNote("ar_unexpected");
               else begin
                  checkOutput("araddr", m_axi_araddr, expR[0].addr);
                  checkOutput("arsize", 64'(m_axi_arsize), 64'(expR[0].size));
                  curRData = expR[0].rdata; curRResp = expR[0].rresp;
                  expR.delete(0);
                  rPending = 1;
               end
            end
            if (m_axi_rvalid && m_axi_rready) begin rTaken = 1; rPending = 0; end
         end
      end
   end

   // Host response monitor: dequeue when allowed and compare against the scoreboard
   initial begin
      resp_yumi_i = 0;
      forever begin
         @(negedge clk_i);
         resp_yumi_i = 0;
         if (!reset_i && yumiEn == 1 && resp_v_o && $urandom_range(0, 3) != 0) begin
            resp_yumi_i = 1;
            if (expResp.size() == 0) failNote("resp_unexpected");
            else checkOutput("resp_data", 64'(resp_data_o), 64'(expResp.pop_front()));
         end
      end
   end

   initial begin
      #950000;
      failNote("watchdog");
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      int n, a0, w0, b0;
      reset_i = 1; cmd_v_i = 0; cmd_data_i = 0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i) reset_i = 0;
      #1;
      checkOutput("rst_cmd_ready", 64'(cmd_ready_and_o), 64'd1);
      checkOutput("rst_resp_v", 64'(resp_v_o), 64'd0);
      checkOutput("rst_resp_count", 64'(resp_count_o), 64'd0);
      checkOutput("rst_error_count", 64'(error_count_o), 64'd0);
      checkOutput("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 64'd0);

      $display("[TB] directed 1: 64b write");
      applyStimulus(1, 2'd3, 64'h0000_0000_0020_0008, 64'h5566778811223344, 2'b00);
      waitIdle();
      checkOutput("hdr_to_awvalid_ge5", 64'((awRiseCyc - hdrCyc) >= 5), 64'd1);

      $display("[TB] directed 2: byte write at offset 3");
      applyStimulus(1, 2'd0, 64'h0000_0000_0020_0003, 64'h0000_0000_0000_00AB, 2'b00);
      waitIdle();

      $display("[TB] directed 3: 32b read held in resp FIFO");
      yumiEn = 0;
      applyStimulus(0, 2'd2, 64'h0000_0000_0020_0004, 64'hCAFEBABE_00000000, 2'b00);
      n = 0;
      while (resp_count_o < 2 && n < 2000) begin @(negedge clk_i); n++; end
      repeat (5) @(negedge clk_i);
      checkOutput("resp_count_two", 64'(resp_count_o), 64'd2);
      yumiEn = 1;
      waitIdle();

      $display("[TB] directed 4: AW delayed 5 cycles");
      readyMode = 1; awDelay = 5; a0 = awHs; w0 = wHs; b0 = bHs;
      applyStimulus(1, 2'd3, 64'h0000_0001_0000_0040, {$urandom, $urandom}, 2'b00);
      waitIdle();
      checkOutput("aw_count", 64'(awHs - a0), 64'd1);
      checkOutput("w_count", 64'(wHs - w0), 64'd1);
      checkOutput("b_count", 64'(bHs - b0), 64'd1);
      checkOutput("w_before_aw", 64'(wHsCyc < awHsCyc), 64'd1);
      checkOutput("aw_on_cycle6", 64'(lastAwVCnt), 64'd6);
      readyMode = 0; awDelay = 0;

      $display("[TB] directed 5: read with SLVERR");
      applyStimulus(0, 2'd3, 64'h0000_0000_0030_0010, {$urandom, $urandom}, 2'b10);
      waitIdle();
      checkOutput("error_count_one", 64'(error_count_o), 64'd1);

      $display("[TB] directed 6: resp FIFO full backpressure");
      yumiEn = 0;
      for (int i = 0; i < 32; i++) randCmd(0);
      n = 0;
      while (resp_count_o < 64 && n < 4000) begin @(negedge clk_i); n++; end
      randCmd(0);
      n = 0;
      while ((rPending || expR.size() != 0 || m_axi_rvalid) && n < 2000) begin @(negedge clk_i); n++; end
      repeat (10) @(negedge clk_i);
      checkOutput("resp_count_full", 64'(resp_count_o), 64'd64);
      checkOutput("rready_low_in_stall", 64'(m_axi_rready), 64'd0);
      for (int i = 0; i < 11; i++) randCmd(1);
      for (int i = 0; i < 3; i++) randCmd(0);
      @(negedge clk_i);
      checkOutput("cmd_full_65th", 64'(cmd_ready_and_o), 64'd0);
      checkOutput("resp_count_still_full", 64'(resp_count_o), 64'd64);
      yumiEn = 1;
      waitIdle();

      $display("[TB] random traffic");
      for (int i = 0; i < 60; i++) randCmd(2);
      waitIdle();
      checkOutput("error_count_final", 64'(error_count_o), 64'(errExp));
      checkOutput("resp_count_final", 64'(resp_count_o), 64'd0);
      checkOutput("cmd_ready_final", 64'(cmd_ready_and_o), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
